// File: rtl/h264_pkg.sv
`default_nettype none
// ============================================================================
// Module : h264_pkg
// Brief  : Shared types and constants for the H.264 residual feeder path.
// Rev    : 1.0 - initial release
// ============================================================================
package h264_pkg;

  localparam int RW         = 9;
  localparam int GAP_CYCLES = 3;

  typedef logic signed [RW-1:0] res_sample_t;
  typedef res_sample_t [3:0]    res_row_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ROW0  = 3'd2,
    ST_ROW1  = 3'd3,
    ST_ROW2  = 3'd4,
    ST_ROW3  = 3'd5,
    ST_GAP   = 3'd6
  } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/h264residual_feeder_if.sv
`default_nettype none
// ============================================================================
// Module : h264residual_feeder_if
// Brief  : Producer-side row handshake plus core-transform-side outputs.
// Rev    : 1.0 - initial release
// ============================================================================
interface h264residual_feeder_if #(
  parameter int RW = h264_pkg::RW
);

  logic            IN_VALID;
  logic [4*RW-1:0] IN_ROW;
  logic            IN_READY;
  logic            TENABLE;
  logic [4*RW-1:0] OUT_ROW;
  logic            OUT_VALID;
  logic            BUSY;

  modport master (
    output IN_VALID, IN_ROW,
    input  IN_READY, TENABLE, OUT_ROW, OUT_VALID, BUSY
  );

  modport slave (
    input  IN_VALID, IN_ROW,
    output IN_READY, TENABLE, OUT_ROW, OUT_VALID, BUSY
  );

endinterface
`default_nettype wire

// File: rtl/h264residual_blockbuf.sv
`default_nettype none
// ============================================================================
// Module : h264residual_blockbuf
// Brief  : Two-slot, four-row residual register file; registered write,
//          combinational read.
// Rev    : 1.0 - initial release
// ============================================================================
module h264residual_blockbuf #(
  parameter int RW = h264_pkg::RW
) (
  input  wire logic            CLK,
  input  wire logic            i_wr_en,
  input  wire logic            i_wr_slot,
  input  wire logic [1:0]      i_wr_row,
  input  wire logic [4*RW-1:0] i_wr_data,
  input  wire logic            i_rd_slot,
  input  wire logic [1:0]      i_rd_row,
  output logic      [4*RW-1:0] o_rd_data
);

  // No reset: stale rows are never read because the full flags gate reads.
  logic [4*RW-1:0] r_mem [0:7];

  always_ff @(posedge CLK) begin
    if (i_wr_en) begin
      r_mem[{i_wr_slot, i_wr_row}] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[{i_rd_slot, i_rd_row}];

endmodule
`default_nettype wire

// File: rtl/h264residual_feeder.sv
`default_nettype none
// ============================================================================
// Module : h264residual_feeder
// Brief  : Ping-pong 4x4 residual buffer replaying each block to the core
//          transform on its fixed 8-cycle cadence.
// Rev    : 1.0 - initial release
// ============================================================================
module h264residual_feeder #(
  parameter int RW = h264_pkg::RW
) (
  input wire logic        CLK,
  input wire logic        RESET,
  h264residual_feeder_if.slave bus
);

  import h264_pkg::*;

  localparam logic [1:0] c_gap_load = 2'(GAP_CYCLES - 1);

  feeder_state_t   r_state;
  feeder_state_t   w_state_next;
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_wrow;
  logic [1:0]      r_full;
  logic [1:0]      r_gap_cnt;
  logic [1:0]      w_gap_next;
  logic            r_tenable;
  logic            r_out_valid;
  logic [4*RW-1:0] r_out_row;
  logic            r_busy;

  logic            w_accept;
  logic            w_blk_done;
  logic            w_free;
  logic [1:0]      w_full_set;
  logic [1:0]      w_full_clr;
  logic [1:0]      w_full_next;
  logic            w_rd_ready;
  logic [1:0]      w_rd_row;
  logic            w_tenable_next;
  logic            w_out_valid_next;
  logic [4*RW-1:0] w_rd_data;

  assign bus.IN_READY  = !r_full[r_wptr];
  assign bus.TENABLE   = r_tenable;
  assign bus.OUT_VALID = r_out_valid;
  assign bus.OUT_ROW   = r_out_row;
  assign bus.BUSY      = r_busy;

  assign w_accept   = bus.IN_VALID && !r_full[r_wptr];
  assign w_blk_done = w_accept && (r_wrow == 2'd3);
  assign w_free     = (r_state == ST_ROW3);

  h264residual_blockbuf #(
    .RW (RW)
  ) u_blockbuf (
    .CLK       (CLK),
    .i_wr_en   (w_accept),
    .i_wr_slot (r_wptr),
    .i_wr_row  (r_wrow),
    .i_wr_data (bus.IN_ROW),
    .i_rd_slot (r_rptr),
    .i_rd_row  (w_rd_row),
    .o_rd_data (w_rd_data)
  );

  // A block completing on this edge counts as ready so TENABLE follows the
  // fourth accepted row by one cycle.
  always_comb begin
    w_full_set = '0;
    w_full_clr = '0;
    if (w_blk_done) w_full_set[r_wptr] = 1'b1;
    if (w_free)     w_full_clr[r_rptr] = 1'b1;
    w_full_next = (r_full & ~w_full_clr) | w_full_set;
    w_rd_ready  = r_full[r_rptr] | w_full_set[r_rptr];
  end

  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap_cnt;
    case (r_state)
      ST_IDLE:  if (w_rd_ready) w_state_next = ST_START;
      ST_START: w_state_next = ST_ROW0;
      ST_ROW0:  w_state_next = ST_ROW1;
      ST_ROW1:  w_state_next = ST_ROW2;
      ST_ROW2:  w_state_next = ST_ROW3;
      ST_ROW3: begin
        w_state_next = ST_GAP;
        w_gap_next   = c_gap_load;
      end
      ST_GAP: begin
        if (r_gap_cnt == 2'd0) begin
          w_state_next = w_rd_ready ? ST_START : ST_IDLE;
        end else begin
          w_gap_next = r_gap_cnt - 2'd1;
        end
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    w_tenable_next   = (w_state_next == ST_START);
    w_out_valid_next = 1'b0;
    w_rd_row         = 2'd0;
    case (w_state_next)
      ST_ROW0: begin w_out_valid_next = 1'b1; w_rd_row = 2'd0; end
      ST_ROW1: begin w_out_valid_next = 1'b1; w_rd_row = 2'd1; end
      ST_ROW2: begin w_out_valid_next = 1'b1; w_rd_row = 2'd2; end
      ST_ROW3: begin w_out_valid_next = 1'b1; w_rd_row = 2'd3; end
      default: begin w_out_valid_next = 1'b0; w_rd_row = 2'd0; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_wrow      <= 2'd0;
      r_full      <= 2'b00;
      r_gap_cnt   <= 2'd0;
      r_tenable   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_gap_cnt   <= w_gap_next;
      r_full      <= w_full_next;
      r_tenable   <= w_tenable_next;
      r_out_valid <= w_out_valid_next;
      r_out_row   <= w_out_valid_next ? w_rd_data : '0;
      r_busy      <= (|w_full_next) || (w_state_next != ST_IDLE);
      if (w_accept)   r_wrow <= r_wrow + 2'd1;
      if (w_blk_done) r_wptr <= ~r_wptr;
      if (w_free)     r_rptr <= ~r_rptr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_h264residual_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_h264residual_feeder
// Brief  : Directed and randomized bench against a block-schedule model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_h264residual_feeder;

  import h264_pkg::*;

  localparam int W = 4*RW;

  // A completed block: edge of its 4th accept, cycle of its TENABLE, rows.
  typedef struct {
    int           r;
    int           t;
    logic [4*W-1:0] data;
  } blk_t;

  logic CLK = 1'b0;
  logic RESET;

  h264residual_feeder_if #(.RW(RW)) bus ();

  h264residual_feeder #(.RW(RW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int           cyc;
  int           n_cmp;
  int           n_fail;
  int           last_t;
  blk_t         q[$];
  logic [W-1:0] part[$];
  int           ten_log[$];

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_row(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive, compare against the schedule model, advance model.
  task automatic do_cycle(input logic v, input logic [W-1:0] row, input logic rst, output logic acc);
    logic         e_ten, e_val, e_rdy, e_busy;
    logic [W-1:0] e_row;
    int           occ;
    blk_t         b;
    if (cyc > 20000) begin
      $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
      $fatal(1, "watchdog expired");
    end
    bus.IN_VALID = v;
    bus.IN_ROW   = row;
    RESET        = rst;
    #1;
    while (q.size() > 0 && q[0].t + 7 < cyc) q.delete(0);
    e_ten = 1'b0; e_val = 1'b0; e_busy = 1'b0; e_row = '0; occ = 0;
    foreach (q[i]) begin
      if (q[i].t == cyc) e_ten = 1'b1;
      if (cyc >= q[i].t + 1 && cyc <= q[i].t + 4) begin
        e_val = 1'b1;
        e_row = q[i].data[(cyc - q[i].t - 1)*W +: W];
      end
      if (q[i].r < cyc && cyc <= q[i].t + 4) occ++;
      if (q[i].r < cyc && cyc <= q[i].t + 7) e_busy = 1'b1;
    end
    e_rdy = (occ < 2);
    check_bit("in_ready",  bus.IN_READY,  e_rdy);
    check_bit("tenable",   bus.TENABLE,   e_ten);
    check_bit("out_valid", bus.OUT_VALID, e_val);
    check_row("out_row",   bus.OUT_ROW,   e_row);
    check_bit("busy",      bus.BUSY,      e_busy);
    if (bus.TENABLE === 1'b1) ten_log.push_back(cyc);
    acc = v && e_rdy && !rst;
    if (rst) begin
      q.delete();
      part.delete();
      last_t = -100;
    end else if (acc) begin
      part.push_back(row);
      if (part.size() == 4) begin
        b.r = cyc;
        b.t = (cyc + 1 > last_t + 8) ? cyc + 1 : last_t + 8;
        for (int k = 0; k < 4; k++) b.data[k*W +: W] = part[k];
        last_t = b.t;
        q.push_back(b);
        part.delete();
      end
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) do_cycle(1'b0, '0, 1'b0, a);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q.size() > 0 || part.size() > 0) && g < 60) begin
      idle(1);
      g++;
    end
    idle(1);
  endtask

  task automatic send_row(input logic [W-1:0] row, input int stall_pct, input bit toggle, output int acc_cyc);
    logic acc, a0;
    int   g;
    acc = 1'b0; g = 0; acc_cyc = -1;
    while (!acc && g < 200) begin
      if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) do_cycle(1'b0, W'($urandom), 1'b0, a0);
      acc_cyc = cyc;
      do_cycle(1'b1, row, 1'b0, acc);
      g++;
    end
    check_bit("row_accepted", acc, 1'b1);
    if (toggle) do_cycle(1'b0, '0, 1'b0, a0);
  endtask

  task automatic send_block(input logic [4*W-1:0] blk, input int stall_pct, input bit toggle);
    int ac;
    for (int k = 0; k < 4; k++) send_row(blk[k*W +: W], stall_pct, toggle, ac);
  endtask

  function automatic logic [W-1:0] rand_row();
    res_row_t r;
    int       s;
    for (int k = 0; k < 4; k++) begin
      s    = int'($urandom_range(510)) - 255;
      r[k] = s[RW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] fill_row(input int a, input int b);
    res_row_t r;
    r[0] = a[RW-1:0]; r[1] = b[RW-1:0]; r[2] = a[RW-1:0]; r[3] = b[RW-1:0];
    return r;
  endfunction

  function automatic logic [4*W-1:0] rand_blk();
    logic [4*W-1:0] d;
    for (int k = 0; k < 4; k++) d[k*W +: W] = rand_row();
    return d;
  endfunction

  initial begin
    logic [4*W-1:0] blk;
    res_row_t       rr;
    int             w_acc, i0, r_a, r_b, c0, ac, g;
    logic           a;

    n_cmp = 0; n_fail = 0; cyc = 0; last_t = -100;
    RESET = 1'b1; bus.IN_VALID = 1'b0; bus.IN_ROW = '0;
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    RESET = 1'b0;

    // Reset state
    idle(2);

    // Single block, rows of samples 1..16
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 4; s++) rr[s] = RW'(4*k + s + 1);
      blk[k*W +: W] = rr;
    end
    i0 = ten_log.size();
    send_block(blk, 0, 1'b0);
    w_acc = cyc - 1;
    drain();
    check_int("single_latency", (ten_log.size() > i0) ? ten_log[i0] : -1, w_acc + 1);

    // Back-pressure: three blocks without gaps
    i0 = ten_log.size();
    for (int b = 0; b < 3; b++) send_block(rand_blk(), 0, 1'b0);
    drain();
    check_int("bp_spacing", (ten_log.size() > i0 + 2) ? ten_log[i0+2] - ten_log[i0] : -1, 16);

    // Extremes
    for (int k = 0; k < 4; k++) blk[k*W +: W] = fill_row(-255, -255);
    send_block(blk, 0, 1'b0);
    for (int k = 0; k < 4; k++) blk[k*W +: W] = fill_row(255, 255);
    send_block(blk, 0, 1'b0);
    for (int k = 0; k < 4; k++) blk[k*W +: W] = fill_row(-255, 255);
    send_block(blk, 0, 1'b0);
    drain();

    // Producer toggling IN_VALID every cycle
    for (int b = 0; b < 2; b++) send_block(rand_blk(), 0, 1'b1);
    drain();

    // Reset during ROW1
    send_block(rand_blk(), 0, 1'b0);
    g = 0;
    while (q.size() > 0 && cyc < q[q.size()-1].t + 2 && g < 20) begin
      idle(1);
      g++;
    end
    check_bit("rst_in_row1", bus.OUT_VALID, 1'b1);
    do_cycle(1'b0, '0, 1'b1, a);
    idle(1);
    send_block(rand_blk(), 0, 1'b0);
    drain();

    // Free/write collision
    i0 = ten_log.size();
    send_block(rand_blk(), 0, 1'b0);
    r_a = cyc - 1;
    for (int k = 0; k < 3; k++) send_row(rand_row(), 0, 1'b0, ac);
    g = 0;
    while (cyc < r_a + 5 && g < 10) begin
      idle(1);
      g++;
    end
    send_row(rand_row(), 0, 1'b0, r_b);
    check_int("coll_last_write", r_b, r_a + 5);
    send_row(rand_row(), 0, 1'b0, c0);
    check_int("coll_slot0_accept", c0, r_a + 6);
    for (int k = 0; k < 3; k++) send_row(rand_row(), 0, 1'b0, ac);
    drain();
    check_int("coll_b_start", (ten_log.size() > i0 + 1) ? ten_log[i0+1] - r_b : -1, 4);
    check_int("coll_spacing", (ten_log.size() > i0 + 1) ? ten_log[i0+1] - ten_log[i0] : -1, 8);

    // Randomized traffic
    for (int b = 0; b < 15; b++) begin
      send_block(rand_blk(), 30, 1'b0);
      if ($urandom_range(3) == 0) idle(int'($urandom_range(12)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
